// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  // Frame FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // Prefix bytes absorbed rather than reported
  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

  // Frame geometry: start + 8 data + parity + stop
  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_BIT_CNT_W  = 3;

  // True when data plus parity bit hold an odd number of ones
  function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic                     par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// 2-flop synchronizer, FILTER_LEN-sample glitch filter and fall detector
// for the raw PS/2 clock pin.
module ps2_input_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic fall_c
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  filt_q;
  logic                  all_low;
  logic                  all_high;

  assign all_low  = (hist_q == '0);
  assign all_high = &hist_q;

  // Fall event is seen the cycle the window first reads all-low
  assign fall_c = filt_q & all_low;

  // Synchronize the pin; idle level is 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], raw};
  end

  // Sample history window and filtered level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '1;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[FILTER_LEN-2:0], sync_q[1]};
      if (all_high)     filt_q <= 1'b1;
      else if (all_low) filt_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: frames 11-bit PS/2 words, absorbs E0/F0 prefixes
// and reports each key event as a one-cycle strobe with qualifiers.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Ps2Clk,
  input  logic       Ps2Data,
  output logic [7:0] ScanCode,
  output logic       ScanExtended,
  output logic       ScanRelease,
  output logic       ScanValid,
  output logic       FrameError
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic                     fall_c;
  logic [1:0]               data_sync_q;
  logic                     data_s;

  ps2_state_e               state_q, state_d;
  logic [PS2_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic                     parity_q, parity_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic                     ext_pend_q, ext_pend_d;
  logic                     brk_pend_q, brk_pend_d;
  logic [7:0]               code_d;
  logic                     ext_d, rel_d, valid_d, err_d;

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (Clock),
    .rst    (Reset),
    .raw    (Ps2Clk),
    .fall_c (fall_c)
  );

  // Data pin only needs synchronizing; it is sampled on clock fall events
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) data_sync_q <= 2'b11;
    else       data_sync_q <= {data_sync_q[0], Ps2Data};
  end

  assign data_s = data_sync_q[1];

  // State and output registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      ScanCode     <= 8'h00;
      ScanExtended <= 1'b0;
      ScanRelease  <= 1'b0;
      ScanValid    <= 1'b0;
      FrameError   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tmo_q        <= tmo_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
      ScanCode     <= code_d;
      ScanExtended <= ext_d;
      ScanRelease  <= rel_d;
      ScanValid    <= valid_d;
      FrameError   <= err_d;
    end
  end

  // Frame FSM, prefix tracking and inactivity timeout
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tmo_d      = '0;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    code_d     = ScanCode;
    ext_d      = ScanExtended;
    rel_d      = ScanRelease;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    if (!fall_c && state_q != IDLE) tmo_d = tmo_q + TMO_W'(1);

    case (state_q)
      IDLE: begin
        if (fall_c && !data_s) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall_c) begin
          shift_d = {data_s, shift_q[PS2_DATA_BITS-1:1]};
          if (bit_cnt_q == PS2_BIT_CNT_W'(PS2_DATA_BITS - 1)) state_d = PARITY;
          else bit_cnt_d = bit_cnt_q + PS2_BIT_CNT_W'(1);
        end
      end
      PARITY: begin
        if (fall_c) begin
          parity_d = data_s;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall_c) begin
          state_d = IDLE;
          if (data_s && ps2_parity_ok(shift_q, parity_q)) begin
            if (shift_q == PS2_PREFIX_EXT) begin
              ext_pend_d = 1'b1;
            end else if (shift_q == PS2_PREFIX_BREAK) begin
              brk_pend_d = 1'b1;
            end else begin
              code_d     = shift_q;
              ext_d      = ext_pend_q;
              rel_d      = brk_pend_q;
              valid_d    = 1'b1;
              ext_pend_d = 1'b0;
              brk_pend_d = 1'b0;
            end
          end else begin
            err_d      = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abandon a stalled frame; only reachable without a fall this cycle
    if (state_q != IDLE && !fall_c && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      state_d    = IDLE;
      tmo_d      = '0;
      err_d      = 1'b1;
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Scoreboard bench for ps2_scan_receiver.
module tb_ps2_scan_receiver;

  localparam int unsigned FILTER_LEN = 4;
  localparam int unsigned TIMEOUT    = 1000;
  localparam int unsigned HALF       = 20;
  localparam int unsigned GAP        = 40;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Ps2Clk;
  logic       Ps2Data;
  logic [7:0] ScanCode;
  logic       ScanExtended;
  logic       ScanRelease;
  logic       ScanValid;
  logic       FrameError;

  typedef struct {
    logic       err;
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic       prev_valid = 1'b0;
  logic       prev_err   = 1'b0;
  logic [9:0] prev_out   = '0;

  ps2_scan_receiver #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Ps2Clk       (Ps2Clk),
    .Ps2Data      (Ps2Data),
    .ScanCode     (ScanCode),
    .ScanExtended (ScanExtended),
    .ScanRelease  (ScanRelease),
    .ScanValid    (ScanValid),
    .FrameError   (FrameError)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_ok(input logic [7:0] code, input logic ext, input logic rel);
    exp_t e;
    e.err = 1'b0; e.code = code; e.ext = ext; e.rel = rel;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.err = 1'b1; e.code = 8'h00; e.ext = 1'b0; e.rel = 1'b0;
    sb.push_back(e);
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge Clock);
    Ps2Data = b;
    repeat (HALF) @(negedge Clock);
    Ps2Clk = 1'b0;
    repeat (HALF) @(negedge Clock);
    Ps2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop_b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ par_bad);
    ps2_bit(stop_b);
    @(negedge Clock);
    Ps2Data = 1'b1;
    repeat (GAP) @(negedge Clock);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(d[i]);
    @(negedge Clock);
    Ps2Data = 1'b1;
  endtask

  // Event monitor: pops expected results as the DUT strobes
  always @(negedge Clock) begin
    if (Reset === 1'b0) begin
      if (ScanValid || FrameError) begin
        chk("valid_err_exclusive", 32'(ScanValid & FrameError), 32'(0));
        chk("pulse_width", 32'((ScanValid & prev_valid) | (FrameError & prev_err)), 32'(0));
        chk("sb_nonempty", 32'(sb.size() != 0), 32'(1));
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("event_is_error", 32'(FrameError), 32'(e.err));
          if (!e.err) begin
            chk("scan_code", 32'(ScanCode), 32'(e.code));
            chk("scan_extended", 32'(ScanExtended), 32'(e.ext));
            chk("scan_release", 32'(ScanRelease), 32'(e.rel));
          end
        end
      end
      if ({ScanCode, ScanExtended, ScanRelease} !== prev_out)
        chk("out_change_needs_valid", 32'(ScanValid), 32'(1));
    end
    prev_valid = ScanValid;
    prev_err   = FrameError;
    prev_out   = {ScanCode, ScanExtended, ScanRelease};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset   = 1'b1;
    Ps2Clk  = 1'b1;
    Ps2Data = 1'b1;
    repeat (5) @(negedge Clock);
    chk("rst_code", 32'(ScanCode), 32'(8'h00));
    chk("rst_ext", 32'(ScanExtended), 32'(0));
    chk("rst_rel", 32'(ScanRelease), 32'(0));
    chk("rst_valid", 32'(ScanValid), 32'(0));
    chk("rst_err", 32'(FrameError), 32'(0));
    Reset = 1'b0;
    repeat (10) @(negedge Clock);

    // Plain make code
    push_ok(8'h69, 1'b0, 1'b0);
    send_frame(8'h69, 1'b0, 1'b1);

    // Release, then same key as make
    send_frame(8'hF0, 1'b0, 1'b1);
    chk("no_output_after_f0", 32'(sb.size()), 32'(0));
    push_ok(8'h70, 1'b0, 1'b1);
    send_frame(8'h70, 1'b0, 1'b1);
    push_ok(8'h70, 1'b0, 1'b0);
    send_frame(8'h70, 1'b0, 1'b1);

    // Extended release
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    push_ok(8'h75, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);

    // Parity error and stop-bit error leave ScanCode alone
    push_err();
    send_frame(8'h72, 1'b1, 1'b1);
    chk("code_held_parity", 32'(ScanCode), 32'(8'h75));
    push_err();
    send_frame(8'h33, 1'b0, 1'b0);
    chk("code_held_stop", 32'(ScanCode), 32'(8'h75));

    // Non-prefix bytes E1 and AA are reported like any key
    push_ok(8'hE1, 1'b0, 1'b0);
    send_frame(8'hE1, 1'b0, 1'b1);
    push_ok(8'hAA, 1'b0, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b1);

    // Error after E0 drops the pending extended flag
    send_frame(8'hE0, 1'b0, 1'b1);
    push_err();
    send_frame(8'h11, 1'b1, 1'b1);
    push_ok(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b1);

    // Timeout after 4 data bits with F0 pending, then a clean frame
    send_frame(8'hF0, 1'b0, 1'b1);
    push_err();
    send_partial(8'h5A, 4);
    repeat (TIMEOUT + 100) @(negedge Clock);
    chk("timeout_drained", 32'(sb.size()), 32'(0));
    push_ok(8'h7A, 1'b0, 1'b0);
    send_frame(8'h7A, 1'b0, 1'b1);

    // 2-cycle Ps2Clk glitch with data low must not start a frame
    @(negedge Clock);
    Ps2Data = 1'b0;
    repeat (5) @(negedge Clock);
    Ps2Clk = 1'b0;
    repeat (2) @(negedge Clock);
    Ps2Clk = 1'b1;
    repeat (10) @(negedge Clock);
    Ps2Data = 1'b1;
    repeat (GAP) @(negedge Clock);
    push_ok(8'h16, 1'b0, 1'b0);
    send_frame(8'h16, 1'b0, 1'b1);

    // Reset mid-frame with E0 pending
    send_frame(8'hE0, 1'b0, 1'b1);
    send_partial(8'h3C, 5);
    #3;
    Reset = 1'b1;
    #1;
    chk("midrst_code", 32'(ScanCode), 32'(8'h00));
    chk("midrst_ext", 32'(ScanExtended), 32'(0));
    chk("midrst_rel", 32'(ScanRelease), 32'(0));
    chk("midrst_valid", 32'(ScanValid), 32'(0));
    chk("midrst_err", 32'(FrameError), 32'(0));
    Ps2Clk  = 1'b1;
    Ps2Data = 1'b1;
    repeat (4) @(negedge Clock);
    Reset = 1'b0;
    repeat (10) @(negedge Clock);
    push_ok(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);

    repeat (50) @(negedge Clock);
    chk("sb_empty_at_end", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
